ram_lsu_port: RTL and testbench
===============================

// Module: ram_lsu_port
// PURPOSE
// Load/store adapter between the core's data-memory request interface and one port (A or B) of the
// RamIO dual-port BRAM wrapper. Converts byte-addressed byte/half/word accesses into the word
// address and byte-enable form RamIO expects. Sequences RamIO's isRequest/requestDone/readValid
// handshake and returns aligned, sign- or zero-extended load data to the core.
// Flags misaligned accesses and RAM handshake timeouts as errors.
// PARAMETERS
// ADDR_W        17   byte address width; word address = addr[ADDR_W-1:2] (15 bits to RamIO)
// TIMEOUT       64   max cycles spent in any RAM wait state before aborting with error
// PORTS
// clk           in   1   system clock; all state on rising edge
// rst_n         in   1   asynchronous active-low reset
// req_valid     in   1   core access request
// req_ready     out  1   adapter can accept a request (high only in IDLE)
// req_we        in   1   1 = store, 0 = load
// req_size      in   2   00 byte, 01 half, 10 word, 11 illegal (treated as misaligned)
// req_unsigned  in   1   load zero-extends when 1, sign-extends when 0
// req_addr      in   ADDR_W  byte address
// req_wdata     in   32  store data, right-justified
// resp_valid    out  1   single-cycle completion pulse
// resp_rdata    out  32  extended load data; 0 for stores and errors
// resp_err      out  1   qualifies resp_valid: misaligned/illegal size or timeout
// ram_we        out  4   byte enables to RamIO we port
// ram_addr      out  15  word address to RamIO
// ram_din       out  32  write data to RamIO
// ram_req       out  1   to RamIO isRequest
// ram_dout      in   32  from RamIO dout
// ram_done      in   1   from RamIO requestDone (high = RamIO idle)
// ram_rvalid    in   1   from RamIO readValid
// BEHAVIOUR
// Reset: state IDLE. req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_req=0, ram_we=0,
//   ram_addr=0, ram_din=0, timeout counter=0.
// FSM: IDLE -> ISSUE -> WAIT_ACK -> WAIT_RD | WAIT_WR -> RESP -> IDLE.
// IDLE: on req_valid & req_ready, latch all req_* fields.
//   Misaligned cases: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
//   Misaligned -> RESP with err=1; no RAM access occurs and ram_req never asserts.
//   Otherwise -> ISSUE.
// Store lanes: byte: ram_we=1<<addr[1:0], ram_din={4{wdata[7:0]}}.
//   half: ram_we=addr[1]?1100:0011, ram_din={2{wdata[15:0]}}.
//   word: ram_we=1111, ram_din=wdata.
//   Loads: ram_we=0000.
// ram_addr/ram_we/ram_din: registered on accept; held stable until RESP.
//   ram_we returns to 0000 in RESP/IDLE.
// ISSUE: ram_req = ram_done (combinational from state). Asserted for exactly one cycle, on the first
//   cycle of ISSUE with ram_done=1; that cycle -> WAIT_ACK.
// WAIT_ACK: wait for ram_done=0 (RamIO has left idle).
//   Then load -> WAIT_RD, store -> WAIT_WR.
// WAIT_RD: on ram_rvalid=1, capture ram_dout and form resp_rdata; -> RESP.
//   Lane select: byte = dout >> (8*addr[1:0]); half = dout >> (16*addr[1]).
//   Extend to 32 per req_unsigned.
// WAIT_WR: on ram_done=1 -> RESP.
// Timeout: counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT_*.
//   Reaching TIMEOUT -> RESP with err=1, rdata=0.
// RESP: resp_valid=1 for one cycle (registered outputs); -> IDLE; no back-pressure from core.
//   Back-to-back: next request accepted in the cycle after RESP, i.e. in IDLE.
//   Outside RESP, resp_rdata and resp_err hold their last value.
// Reset mid-operation: ram_req and ram_we drop immediately (async). Any pending RamIO access
//   is abandoned; its readValid or requestDone is ignored in IDLE.
// TESTING (bench pairs DUT with a RamIO behavioural model: 2-cycle read, 1-cycle write)
// Store byte: wdata=0x000000A5, addr=0x00006 -> ram_addr=0x0001, ram_we=0100, ram_din=0xA5A5A5A5,
//   one ram_req pulse, resp_valid with err=0, rdata=0.
// Load half signed: addr=0x00002, ram_dout=0x80FF1234 -> resp_rdata=0x000080FF sign-extended,
//   i.e. 0xFFFF80FF; with req_unsigned=1 -> 0x000080FF.
// Load byte unsigned: addr offset 3, ram_dout=0x80FF1234 -> 0x00000080.
//   Same access signed -> 0xFFFFFF80.
// Misaligned word: addr=0x00005 -> resp_valid+resp_err one cycle after accept; ram_req stays 0.
// Timeout: model never deasserts requestDone after ram_req -> err response exactly TIMEOUT
//   cycles after ISSUE entry; req_ready returns to 1 the following cycle.
// Async reset asserted during WAIT_RD -> outputs at reset values within the same cycle.
//   After release, a new load completes normally and the stale readValid is ignored.

Source files
------------

// File: rtl/ram_lsu_port.sv
// Load/store adapter from the core's byte-addressed data-memory port to one RamIO BRAM port.
// Steers byte lanes, sequences the RamIO handshake, extends load data and reports errors.
module ram_lsu_port #(
  parameter int ADDR_W  = 17,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_req,
  input  logic [31:0]       ram_dout,
  input  logic              ram_done,
  input  logic              ram_rvalid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_RD,
    S_WAIT_WR,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-3:0] ram_addr_q, ram_addr_d;
  logic [3:0]        ram_we_q, ram_we_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              misaligned;
  logic [3:0]        lane_we;
  logic [31:0]       lane_din;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;
  logic              tmo_hit;
  logic              finish;
  logic              fail;
  logic              load_done;

  // Store lane steering and alignment check for the request currently offered.
  always_comb begin
    misaligned = 1'b0;
    lane_we    = 4'b0000;
    lane_din   = req_wdata;
    case (req_size)
      2'b00: begin
        lane_we  = 4'b0001 << req_addr[1:0];
        lane_din = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr[0];
        lane_we    = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_din   = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |req_addr[1:0];
        lane_we    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
    if (!req_we) lane_we = 4'b0000;
  end

  always_comb begin
    byte_sel = 8'(ram_dout >> {off_q, 3'b000});
    half_sel = 16'(ram_dout >> {off_q[1], 4'b0000});
    case (size_q)
      2'b00:   load_data = unsigned_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = unsigned_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = ram_dout;
    endcase
  end

  assign tmo_hit = (cnt_q == TMO_LAST);

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    off_d        = off_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = ram_we_q;
    ram_din_d    = ram_din_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    finish       = 1'b0;
    fail         = 1'b0;
    load_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_store_d = req_we;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          off_d      = req_addr[1:0];
          ram_addr_d = req_addr[ADDR_W-1:2];
          ram_din_d  = lane_din;
          ram_we_d   = misaligned ? 4'b0000 : lane_we;
          cnt_d      = '0;
          if (misaligned) begin
            finish = 1'b1;
            fail   = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ram_done) begin
          state_d = S_WAIT_ACK;
        end else if (tmo_hit) begin
          finish = 1'b1;
          fail   = 1'b1;
        end
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!ram_done) begin
          state_d = is_store_q ? S_WAIT_WR : S_WAIT_RD;
        end else if (tmo_hit) begin
          finish = 1'b1;
          fail   = 1'b1;
        end
      end
      S_WAIT_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ram_rvalid) begin
          finish    = 1'b1;
          load_done = 1'b1;
        end else if (tmo_hit) begin
          finish = 1'b1;
          fail   = 1'b1;
        end
      end
      S_WAIT_WR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ram_done) begin
          finish = 1'b1;
        end else if (tmo_hit) begin
          finish = 1'b1;
          fail   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        ram_we_d = 4'b0000;
      end
    endcase

    // Every completion path, good or bad, funnels through the one-cycle RESP state.
    if (finish) begin
      state_d      = S_RESP;
      resp_valid_d = 1'b1;
      resp_err_d   = fail;
      resp_rdata_d = load_done ? load_data : 32'd0;
      ram_we_d     = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      is_store_q   <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      off_q        <= 2'b00;
      ram_addr_q   <= '0;
      ram_we_q     <= 4'b0000;
      ram_din_q    <= 32'd0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      off_q        <= off_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_din_q    <= ram_din_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // ram_req follows ram_done so the request is only raised while RamIO reports idle.
  assign req_ready  = (state_q == S_IDLE);
  assign ram_req    = (state_q == S_ISSUE) && ram_done;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ram_lsu_port.sv
// Bench for ram_lsu_port: pairs the adapter with a RamIO model (2-cycle read, 1-cycle write)
// and checks directed vectors, timeout, async reset and randomized traffic against a byte model.
module tb_ram_lsu_port;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWe = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqUnsigned = 1'b0;
  logic [16:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respErr;
  logic [3:0]  ramWe;
  logic [14:0] ramAddr;
  logic [31:0] ramDin;
  logic        ramReq;
  logic [31:0] ramDout = '0;
  logic        ramDone = 1'b1;
  logic        ramRvalid = 1'b0;

  ram_lsu_port #(.ADDR_W(17), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rstN),
    .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe), .req_size(reqSize),
    .req_unsigned(reqUnsigned), .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(respValid), .resp_rdata(respRdata), .resp_err(respErr),
    .ram_we(ramWe), .ram_addr(ramAddr), .ram_din(ramDin), .ram_req(ramReq),
    .ram_dout(ramDout), .ram_done(ramDone), .ram_rvalid(ramRvalid)
  );

  always #5 clk = ~clk;

  // RamIO model: accepts a request while idle, then finishes after 2 cycles (read) or 1 (write).
  logic [31:0] mem [0:32767];
  logic        busy = 1'b0;
  int          timer = 0;
  logic        pendWrite = 1'b0;
  logic [3:0]  pendWe = '0;
  logic [14:0] pendAddr = '0;
  logic [31:0] pendDin = '0;
  logic        hangMode = 1'b0;

  always @(posedge clk) begin
    ramRvalid <= 1'b0;
    if (busy) begin
      if (timer <= 1) begin
        busy    <= 1'b0;
        ramDone <= 1'b1;
        if (pendWrite) begin
          for (int b = 0; b < 4; b++)
            if (pendWe[b]) mem[pendAddr][8*b +: 8] <= pendDin[8*b +: 8];
        end else begin
          ramRvalid <= 1'b1;
          ramDout   <= mem[pendAddr];
        end
      end else begin
        timer <= timer - 1;
      end
    end else if (ramReq && !hangMode) begin
      busy      <= 1'b1;
      ramDone   <= 1'b0;
      pendAddr  <= ramAddr;
      pendWe    <= ramWe;
      pendDin   <= ramDin;
      pendWrite <= |ramWe;
      timer     <= (|ramWe) ? 1 : 2;
    end
  end

  // Records each ram_req pulse and what the adapter presented with it.
  int          pulseCount = 0;
  logic [3:0]  capWe = '0;
  logic [14:0] capAddr = '0;
  logic [31:0] capDin = '0;

  always @(posedge clk) begin
    if (ramReq) begin
      pulseCount <= pulseCount + 1;
      capWe      <= ramWe;
      capAddr    <= ramAddr;
      capDin     <= ramDin;
    end
  end

  int checksTotal = 0;
  int checksPassed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
  endtask

  logic        gotOk;
  logic [31:0] gotRdata;
  logic        gotErr;
  int          gotCycles;
  int          gotPulses;
  logic [3:0]  gotWeResp;
  logic        gotReadyAfter;
  logic        gotValidAfter;

  // One complete access; gotCycles counts edges from the accept edge to the response edge.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [16:0] addr, input logic [31:0] wdata);
    int startPulses;
    @(negedge clk);
    checkOutput("req_ready before request", 32'(reqReady), 32'd1);
    reqValid    = 1'b1;
    reqWe       = we;
    reqSize     = size;
    reqUnsigned = uns;
    reqAddr     = addr;
    reqWdata    = wdata;
    startPulses = pulseCount;
    @(negedge clk);
    reqValid  = 1'b0;
    gotCycles = 0;
    while (!respValid && gotCycles < 200) begin
      @(negedge clk);
      gotCycles++;
    end
    gotOk     = respValid;
    gotRdata  = respRdata;
    gotErr    = respErr;
    gotWeResp = ramWe;
    gotPulses = pulseCount - startPulses;
    @(negedge clk);
    gotReadyAfter = reqReady;
    gotValidAfter = respValid;
  endtask

  // Byte-level reference memory covering byte addresses 0..63.
  logic [7:0] refMem [0:63];

  function automatic logic [31:0] refLoad(input logic [1:0] size, input logic uns, input int addr);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(refMem[addr + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic refStore(input logic [1:0] size, input int addr, input logic [31:0] wdata);
    for (int i = 0; i < (1 << size); i++) refMem[addr + i] = wdata[8*i +: 8];
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expRdata;
    logic [3:0]  expWe;
    logic [31:0] expDin;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        rWe;
    logic [1:0]  rSize;
    logic        rUns;
    int          rAddr;
    logic [31:0] rData;
    logic [31:0] expRd;
    logic        mis;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 17'h00000, 32'h80FF1234, 1'b0, 32'h00000000, 4'b1111, 32'h80FF1234};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 17'h00004, 32'h00000000, 1'b0, 32'h00000000, 4'b1111, 32'h00000000};
    vecs[2]  = '{1'b0, 2'd1, 1'b0, 17'h00002, 32'h0,        1'b0, 32'hFFFF80FF, 4'b0000, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 17'h00002, 32'h0,        1'b0, 32'h000080FF, 4'b0000, 32'h0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 17'h00003, 32'h0,        1'b0, 32'h00000080, 4'b0000, 32'h0};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 17'h00003, 32'h0,        1'b0, 32'hFFFFFF80, 4'b0000, 32'h0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 17'h00000, 32'h0,        1'b0, 32'h00001234, 4'b0000, 32'h0};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 17'h00001, 32'h0,        1'b0, 32'h00000012, 4'b0000, 32'h0};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 17'h00006, 32'h000000A5, 1'b0, 32'h00000000, 4'b0100, 32'hA5A5A5A5};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 17'h00004, 32'h0,        1'b0, 32'h00A50000, 4'b0000, 32'h0};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 17'h00004, 32'h1234BEEF, 1'b0, 32'h00000000, 4'b0011, 32'hBEEFBEEF};
    vecs[11] = '{1'b0, 2'd2, 1'b1, 17'h00004, 32'h0,        1'b0, 32'h00A5BEEF, 4'b0000, 32'h0};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 17'h00005, 32'h0,        1'b1, 32'h00000000, 4'b0000, 32'h0};
    vecs[13] = '{1'b1, 2'd1, 1'b0, 17'h00001, 32'h5555AAAA, 1'b1, 32'h00000000, 4'b0000, 32'h0};
    vecs[14] = '{1'b0, 2'd3, 1'b0, 17'h00000, 32'h0,        1'b1, 32'h00000000, 4'b0000, 32'h0};
    vecs[15] = '{1'b0, 2'd0, 1'b1, 17'h00000, 32'h0,        1'b0, 32'h00000034, 4'b0000, 32'h0};

    // Reset values while reset is held.
    #2 rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", 32'(reqReady), 32'd1);
    checkOutput("reset resp_valid", 32'(respValid), 32'd0);
    checkOutput("reset resp_err", 32'(respErr), 32'd0);
    checkOutput("reset resp_rdata", respRdata, 32'd0);
    checkOutput("reset ram_req", 32'(ramReq), 32'd0);
    checkOutput("reset ram_we", 32'(ramWe), 32'd0);
    checkOutput("reset ram_addr", 32'(ramAddr), 32'd0);
    checkOutput("reset ram_din", ramDin, 32'd0);
    rstN = 1'b1;

    // Directed vectors, applied back to back.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d resp_valid", i), 32'(gotOk), 32'd1);
      checkOutput($sformatf("vec%0d resp_rdata", i), gotRdata, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d resp_err", i), 32'(gotErr), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d ram_req pulses", i), 32'(gotPulses), vecs[i].expErr ? 32'd0 : 32'd1);
      if (vecs[i].expErr) begin
        checkOutput($sformatf("vec%0d error latency", i), 32'(gotCycles), 32'd0);
      end else begin
        checkOutput($sformatf("vec%0d ram_addr", i), 32'(capAddr), 32'(vecs[i].addr[16:2]));
        checkOutput($sformatf("vec%0d ram_we", i), 32'(capWe), 32'(vecs[i].expWe));
        if (vecs[i].we) checkOutput($sformatf("vec%0d ram_din", i), capDin, vecs[i].expDin);
      end
      checkOutput($sformatf("vec%0d ram_we in resp", i), 32'(gotWeResp), 32'd0);
      checkOutput($sformatf("vec%0d ready after resp", i), 32'(gotReadyAfter), 32'd1);
      checkOutput($sformatf("vec%0d single-cycle resp", i), 32'(gotValidAfter), 32'd0);
    end

    // RamIO that never leaves idle after a request must trip the timeout.
    @(negedge clk);
    hangMode = 1'b1;
    applyStimulus(1'b0, 2'd2, 1'b0, 17'h00000, 32'h0);
    hangMode = 1'b0;
    checkOutput("timeout resp_valid", 32'(gotOk), 32'd1);
    checkOutput("timeout latency", 32'(gotCycles), 32'(TIMEOUT));
    checkOutput("timeout resp_err", 32'(gotErr), 32'd1);
    checkOutput("timeout resp_rdata", gotRdata, 32'd0);
    checkOutput("timeout ram_req pulses", 32'(gotPulses), 32'd1);
    checkOutput("timeout ready after", 32'(gotReadyAfter), 32'd1);

    // Randomized traffic over a 64-byte window, first filled with known words.
    for (int w = 0; w < 16; w++) begin
      rData = $urandom;
      refStore(2'd2, w * 4, rData);
      applyStimulus(1'b1, 2'd2, 1'b0, 17'(w * 4), rData);
      checkOutput($sformatf("init%0d resp_err", w), 32'(gotErr), 32'd0);
    end
    for (int n = 0; n < 150; n++) begin
      rWe   = 1'($urandom_range(0, 1));
      rSize = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rUns  = 1'($urandom_range(0, 1));
      rAddr = int'($urandom_range(0, 63));
      rData = $urandom;
      mis   = (rSize == 2'd3) || ((rAddr % (1 << rSize)) != 0);
      expRd = 32'd0;
      if (!mis) begin
        if (rWe) refStore(rSize, rAddr, rData);
        else expRd = refLoad(rSize, rUns, rAddr);
      end
      applyStimulus(rWe, rSize, rUns, 17'(rAddr), rData);
      checkOutput($sformatf("rand%0d resp_valid", n), 32'(gotOk), 32'd1);
      checkOutput($sformatf("rand%0d resp_err", n), 32'(gotErr), 32'(mis));
      checkOutput($sformatf("rand%0d resp_rdata", n), gotRdata, expRd);
      checkOutput($sformatf("rand%0d ram_req pulses", n), 32'(gotPulses), mis ? 32'd0 : 32'd1);
    end

    // Async reset while waiting for read data; the stale readValid must be ignored.
    applyStimulus(1'b0, 2'd2, 1'b0, 17'h0003C, 32'h0);
    checkOutput("pre-reset load", gotRdata, refLoad(2'd2, 1'b0, 60));
    @(negedge clk);
    reqValid = 1'b1;
    reqWe    = 1'b0;
    reqSize  = 2'd2;
    reqAddr  = 17'h0003C;
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid-op ram_addr before reset", 32'(ramAddr), 32'd15);
    rstN = 1'b0;
    #1;
    checkOutput("mid-op reset req_ready", 32'(reqReady), 32'd1);
    checkOutput("mid-op reset ram_req", 32'(ramReq), 32'd0);
    checkOutput("mid-op reset ram_we", 32'(ramWe), 32'd0);
    checkOutput("mid-op reset ram_addr", 32'(ramAddr), 32'd0);
    checkOutput("mid-op reset resp_valid", 32'(respValid), 32'd0);
    checkOutput("mid-op reset resp_rdata", respRdata, 32'd0);
    checkOutput("mid-op reset resp_err", 32'(respErr), 32'd0);
    #2 rstN = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("stale rvalid ignored", 32'(respValid), 32'd0);
    checkOutput("idle after stale rvalid", 32'(reqReady), 32'd1);
    applyStimulus(1'b0, 2'd1, 1'b1, 17'h0003E, 32'h0);
    checkOutput("post-reset load resp_valid", 32'(gotOk), 32'd1);
    checkOutput("post-reset load resp_err", 32'(gotErr), 32'd0);
    checkOutput("post-reset load resp_rdata", gotRdata, refLoad(2'd1, 1'b1, 62));

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
